// File: rtl/led_array_pwm_spi.sv
// led_array_pwm_spi: SPI-configured LED array with per-channel PWM duty and global blink.
// SPI pins are oversampled on i_CLK; frames are 8-bit command + 24-bit data, MSB first.
module led_array_pwm_spi #(
    parameter int unsigned CH_NUM   = 32,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESC    = 1
) (
    input  logic              i_CLK,
    input  logic              i_RESET_n,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_ENA_n,
    input  logic              i_SPI_DATA,
    input  logic              i_ENA_p,
    output logic [CH_NUM-1:0] o_LED,
    output logic              o_FRAME_OK,
    output logic              o_FRAME_ERR,
    output logic              o_BUSY
);

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned BCNT_W     = 6;
    localparam int unsigned HALF_W     = 16;
    localparam int unsigned CH_W       = 6;
    localparam int unsigned PRESC_W    = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [BCNT_W-1:0]   BCNT_FULL = BCNT_W'(FRAME_BITS);
    localparam logic [BCNT_W-1:0]   BCNT_SAT  = BCNT_W'(FRAME_BITS + 1);
    localparam logic [PRESC_W-1:0]  PRESC_TOP = PRESC_W'(PRESC - 1);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_DUTY  = 2'b01,
        OP_BLINK = 2'b10,
        OP_BCAST = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [CH_W-1:0]  ch;
        logic [23:0]      data;
    } frame_t;

    // SPI pin synchronisers, edge-detect history and registered edge events
    logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
    logic ena_s1_q, ena_s1_d, ena_s2_q, ena_s2_d, ena_prev_q, ena_prev_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d, dat_prev_q, dat_prev_d;
    logic sck_rise_q, sck_rise_d, ena_fall_q, ena_fall_d, ena_rise_q, ena_rise_d;

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic                  ok_q, ok_d, err_q, err_d, busy_q, busy_d;

    logic [PWM_BITS-1:0]   stage_q  [CH_NUM];
    logic [PWM_BITS-1:0]   stage_d  [CH_NUM];
    logic [PWM_BITS-1:0]   active_q [CH_NUM];
    logic [PWM_BITS-1:0]   active_d [CH_NUM];

    logic                  blink_en_q, blink_en_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [HALF_W-1:0]     per_q, per_d;
    logic                  phase_q, phase_d;
    logic                  blink_wr;

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic                  step, wrap;
    logic [CH_NUM-1:0]     led_q, led_d;

    frame_t                frame_c;

    assign frame_c = frame_t'(sr_q);

    // Synchronisers and edge detection
    always_comb begin
        sck_s1_d   = i_SPI_CLK;
        sck_s2_d   = sck_s1_q;
        sck_prev_d = sck_s2_q;
        ena_s1_d   = i_SPI_ENA_n;
        ena_s2_d   = ena_s1_q;
        ena_prev_d = ena_s2_q;
        dat_s1_d   = i_SPI_DATA;
        dat_s2_d   = dat_s1_q;
        dat_prev_d = dat_s2_q;
        sck_rise_d = sck_s2_q & ~sck_prev_q;
        ena_fall_d = ~ena_s2_q & ena_prev_q;
        ena_rise_d = ena_s2_q & ~ena_prev_q;
        busy_d     = ~ena_s2_q;
    end

    // Frame assembly, validation and command decode
    always_comb begin
        sr_d       = sr_q;
        bcnt_d     = bcnt_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        stage_d    = stage_q;
        blink_en_d = blink_en_q;
        half_d     = half_q;
        blink_wr   = 1'b0;

        if (ena_fall_q) begin
            bcnt_d = '0;
        end
        if (sck_rise_q && !ena_prev_q) begin
            sr_d = {sr_q[FRAME_BITS-2:0], dat_prev_q};
            if (bcnt_d != BCNT_SAT) begin
                bcnt_d = bcnt_d + BCNT_W'(1);
            end
        end

        if (ena_rise_q) begin
            if (bcnt_q != BCNT_FULL) begin
                err_d = 1'b1;
            end else begin
                case (frame_c.op)
                    OP_NOP: begin
                        ok_d = 1'b1;
                    end
                    OP_DUTY: begin
                        if ({1'b0, frame_c.ch} >= 7'(CH_NUM)) begin
                            err_d = 1'b1;
                        end else begin
                            ok_d = 1'b1;
                            for (int k = 0; k < CH_NUM; k++) begin
                                if (frame_c.ch == CH_W'(k)) begin
                                    stage_d[k] = frame_c.data[PWM_BITS-1:0];
                                end
                            end
                        end
                    end
                    OP_BLINK: begin
                        ok_d       = 1'b1;
                        blink_en_d = frame_c.data[0];
                        half_d     = frame_c.data[23:8];
                        blink_wr   = 1'b1;
                    end
                    OP_BCAST: begin
                        ok_d = 1'b1;
                        for (int k = 0; k < CH_NUM; k++) begin
                            stage_d[k] = frame_c.data[PWM_BITS-1:0];
                        end
                    end
                endcase
            end
        end
    end

    // PWM timebase, active-duty reload, blink phase and LED compare
    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        per_d    = per_q;
        phase_d  = phase_q;
        led_d    = '0;

        step = (presc_q == PRESC_TOP);
        wrap = i_ENA_p && step && (cnt_q == DUTY_MAX);

        if (!i_ENA_p) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (step) begin
            presc_d = '0;
            cnt_d   = cnt_q + PWM_BITS'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end

        // Reload samples the pre-commit staging value, so a same-cycle commit waits a period
        if (wrap || !i_ENA_p) begin
            active_d = stage_q;
        end

        if (blink_wr || !blink_en_q || (half_q == '0)) begin
            per_d   = '0;
            phase_d = 1'b1;
        end else if (wrap) begin
            if ((per_q + HALF_W'(1)) == half_q) begin
                per_d   = '0;
                phase_d = ~phase_q;
            end else begin
                per_d = per_q + HALF_W'(1);
            end
        end

        for (int k = 0; k < CH_NUM; k++) begin
            led_d[k] = i_ENA_p && phase_q &&
                       ((cnt_q < active_q[k]) || (active_q[k] == DUTY_MAX));
        end
    end

    // State registers; SPI clock/enable history resets to the idle-high level
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            sck_s1_q   <= 1'b1;
            sck_s2_q   <= 1'b1;
            sck_prev_q <= 1'b1;
            ena_s1_q   <= 1'b1;
            ena_s2_q   <= 1'b1;
            ena_prev_q <= 1'b1;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
            dat_prev_q <= 1'b0;
            sck_rise_q <= 1'b0;
            ena_fall_q <= 1'b0;
            ena_rise_q <= 1'b0;
            sr_q       <= '0;
            bcnt_q     <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            stage_q    <= '{default: '0};
            active_q   <= '{default: '0};
            blink_en_q <= 1'b0;
            half_q     <= '0;
            per_q      <= '0;
            phase_q    <= 1'b1;
            presc_q    <= '0;
            cnt_q      <= '0;
            led_q      <= '0;
        end else begin
            sck_s1_q   <= sck_s1_d;
            sck_s2_q   <= sck_s2_d;
            sck_prev_q <= sck_prev_d;
            ena_s1_q   <= ena_s1_d;
            ena_s2_q   <= ena_s2_d;
            ena_prev_q <= ena_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            dat_prev_q <= dat_prev_d;
            sck_rise_q <= sck_rise_d;
            ena_fall_q <= ena_fall_d;
            ena_rise_q <= ena_rise_d;
            sr_q       <= sr_d;
            bcnt_q     <= bcnt_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            stage_q    <= stage_d;
            active_q   <= active_d;
            blink_en_q <= blink_en_d;
            half_q     <= half_d;
            per_q      <= per_d;
            phase_q    <= phase_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
        end
    end

    assign o_LED       = led_q;
    assign o_FRAME_OK  = ok_q;
    assign o_FRAME_ERR = err_q;
    assign o_BUSY      = busy_q;

endmodule
